// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (IF) and data (D) requesters, D has priority.
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  output logic        IF_VALID,
  output logic        IF_STALL,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [2:0]  D_TYPE,
  output logic [31:0] D_RDATA,
  output logic        D_VALID,
  output logic        D_STALL,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [2:0]  M_TYPE,
  input  logic [31:0] M_RDATA
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic       OWN_D  = 1'b0;
  localparam logic       OWN_IF = 1'b1;
  localparam logic [3:0] LAT4   = 4'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT must be 1..15 and STARVE_MAX 0..15");
  end

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_fetch, gnt_data, done, force_if;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_q, starve_d;

  assign force_if = IF_REQ && (starve_q == 4'(STARVE_MAX));

  always_comb begin
    starve_d = starve_q;
    if (!IF_REQ || gnt_fetch) starve_d = 4'd0;
    else if (gnt_data)        starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) starve_q <= 4'd0;
    else     starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // Grants and completions are masked during reset so the memory never sees a
  // strobe and no stale access completes.
  assign gnt_fetch = !RST && (state_q == IDLE) && IF_REQ && (!D_REQ || force_if);
  assign gnt_data  = !RST && (state_q == IDLE) && D_REQ && !gnt_fetch;
  assign done      = !RST && (state_q == BUSY) && (cnt_q == 4'd1);

  assign IF_VALID = done && (owner_q == OWN_IF);
  assign D_VALID  = done && (owner_q == OWN_D);
  assign IF_RDATA = IF_VALID ? M_RDATA : 32'd0;
  assign D_RDATA  = (D_VALID && !D_WE) ? M_RDATA : 32'd0;
  assign IF_STALL = IF_REQ && !IF_VALID;
  assign D_STALL  = D_REQ && !D_VALID;

  always_comb begin
    M_REQ   = 1'b0;
    M_WE    = 1'b0;
    M_ADDR  = 32'd0;
    M_WDATA = 32'd0;
    M_TYPE  = 3'd0;
    if (gnt_data) begin
      M_REQ   = 1'b1;
      M_WE    = D_WE;
      M_ADDR  = D_ADDR;
      M_WDATA = D_WDATA;
      M_TYPE  = D_TYPE;
    end else if (gnt_fetch) begin
      M_REQ   = 1'b1;
      M_ADDR  = IF_ADDR;
      M_TYPE  = 3'b010;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (gnt_fetch || gnt_data) begin
      state_d = BUSY;
      owner_d = gnt_fetch ? OWN_IF : OWN_D;
      cnt_d   = LAT4;
    end else if (state_q == BUSY) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= OWN_D;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (next-free cycle, completion cycle, D-streak count).
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IF_REQ = 1'b0;
  logic [31:0] IF_ADDR = '0;
  logic [31:0] IF_RDATA;
  logic        IF_VALID, IF_STALL;
  logic        D_REQ = 1'b0;
  logic        D_WE = 1'b0;
  logic [31:0] D_ADDR = '0;
  logic [31:0] D_WDATA = '0;
  logic [2:0]  D_TYPE = '0;
  logic [31:0] D_RDATA;
  logic        D_VALID, D_STALL;
  logic        M_REQ, M_WE;
  logic [31:0] M_ADDR, M_WDATA;
  logic [2:0]  M_TYPE;
  logic [31:0] M_RDATA = '0;

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_VALID(IF_VALID), .IF_STALL(IF_STALL),
    .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_TYPE(D_TYPE),
    .D_RDATA(D_RDATA), .D_VALID(D_VALID), .D_STALL(D_STALL),
    .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_TYPE(M_TYPE),
    .M_RDATA(M_RDATA)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0, n_err = 0;
  int cyc = 0, next_free = 0, done_cyc = -1, starve = 0;
  bit done_who = 1'b0;
  bit last_ifv = 1'b0, last_dv = 1'b0, hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Advance one cycle; requesters retire after seeing their VALID.
  task automatic tick();
    @(posedge CLK); #1;
    RST = 1'b0;
    M_RDATA = $urandom;
    if (!hold) begin
      if (last_ifv) IF_REQ = 1'b0;
      if (last_dv)  D_REQ  = 1'b0;
    end
  endtask

  task automatic check_cycle();
    logic e_ifv, e_dv, e_mreq, e_mwe;
    logic [31:0] e_ifr, e_dr, e_ma, e_mwd;
    logic [2:0] e_mt;
    bit win_if, force_if;
    #2;
    e_ifv = 0; e_dv = 0; e_mreq = 0; e_mwe = 0;
    e_ifr = 0; e_dr = 0; e_ma = 0; e_mwd = 0; e_mt = 0;
    if (RST) begin
      next_free = cyc + 1;
      done_cyc  = -1;
      starve    = 0;
    end else begin
      if (cyc == done_cyc) begin
        if (done_who) begin e_ifv = 1; e_ifr = M_RDATA; end
        else begin e_dv = 1; e_dr = D_WE ? 32'd0 : M_RDATA; end
      end
      force_if = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      force_if = IF_REQ && (starve == SMAX);
`endif
      if (cyc >= next_free && (IF_REQ || D_REQ)) begin
        win_if = IF_REQ && (!D_REQ || force_if);
        e_mreq = 1;
        if (win_if) begin
          e_ma = IF_ADDR; e_mt = 3'b010;
        end else begin
          e_mwe = D_WE; e_ma = D_ADDR; e_mwd = D_WDATA; e_mt = D_TYPE;
        end
        done_cyc  = cyc + LAT;
        done_who  = win_if;
        next_free = cyc + LAT + 1;
        if (win_if) starve = 0;
        else if (IF_REQ) starve++;
      end
      if (!IF_REQ) starve = 0;
    end
    chk("if_valid", IF_VALID, e_ifv);
    chk("if_rdata", IF_RDATA, e_ifr);
    chk("if_stall", IF_STALL, IF_REQ && !e_ifv);
    chk("d_valid",  D_VALID,  e_dv);
    chk("d_rdata",  D_RDATA,  e_dr);
    chk("d_stall",  D_STALL,  D_REQ && !e_dv);
    chk("m_req",    M_REQ,    e_mreq);
    chk("m_we",     M_WE,     e_mwe);
    chk("m_addr",   M_ADDR,   e_ma);
    chk("m_wdata",  M_WDATA,  e_mwd);
    chk("m_type",   M_TYPE,   e_mt);
    last_ifv = IF_VALID;
    last_dv  = D_VALID;
    cyc++;
  endtask

  task automatic rst_cycle();
    tick();
    RST = 1'b1; IF_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
    check_cycle();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin tick(); check_cycle(); end
  endtask

  int ifv_cnt;

  initial begin
    // Reset state (RST asserted from time 0)
    rst_cycle();
    idle_cycles(2);

    // IF-only fetch
    rst_cycle();
    tick(); IF_REQ = 1; IF_ADDR = 32'h100; check_cycle();
    chk("t1_mreq0", M_REQ, 1); chk("t1_maddr0", M_ADDR, 32'h100);
    tick(); check_cycle(); chk("t1_stall1", IF_STALL, 1);
    tick(); M_RDATA = 32'h13; check_cycle();
    chk("t1_ifv2", IF_VALID, 1); chk("t1_ifr2", IF_RDATA, 32'h13); chk("t1_stall2", IF_STALL, 0);
    idle_cycles(2);

    // Simultaneous D load and IF fetch
    rst_cycle();
    tick(); D_REQ = 1; D_WE = 0; D_ADDR = 32'h2000; D_TYPE = 3'b010;
    IF_REQ = 1; IF_ADDR = 32'h104; check_cycle();
    chk("t2_dgnt", M_ADDR, 32'h2000);
    idle_cycles(1);
    tick(); check_cycle(); chk("t2_dv2", D_VALID, 1);
    tick(); check_cycle(); chk("t2_ifgnt3", M_REQ, 1); chk("t2_ifaddr3", M_ADDR, 32'h104);
    idle_cycles(1);
    tick(); check_cycle(); chk("t2_ifv5", IF_VALID, 1);
    idle_cycles(2);

    // Store
    rst_cycle();
    tick(); D_REQ = 1; D_WE = 1; D_ADDR = 32'h3000; D_WDATA = 32'hDEADBEEF; D_TYPE = 3'b010;
    check_cycle();
    chk("t3_mwe", M_WE, 1); chk("t3_mwd", M_WDATA, 32'hDEADBEEF); chk("t3_mt", M_TYPE, 3'b010);
    idle_cycles(1);
    tick(); check_cycle(); chk("t3_dv", D_VALID, 1); chk("t3_drd", D_RDATA, 0);
    idle_cycles(2);
    D_WE = 0;

    // Reset mid-access
    rst_cycle();
    tick(); IF_REQ = 1; IF_ADDR = 32'h200; check_cycle();
    tick(); RST = 1; check_cycle();
    tick(); check_cycle(); chk("t4_noifv", IF_VALID, 0); chk("t4_regnt", M_REQ, 1);
    idle_cycles(4);

    // Abandoned fetch
    rst_cycle();
    tick(); IF_REQ = 1; IF_ADDR = 32'h300; check_cycle();
    tick(); IF_REQ = 0; check_cycle(); chk("t5_stall", IF_STALL, 0);
    tick(); D_REQ = 1; D_WE = 0; D_ADDR = 32'h400; check_cycle();
    chk("t5_ifv", IF_VALID, 1); chk("t5_nogntv", M_REQ, 0);
    tick(); check_cycle(); chk("t5_gnt3", M_REQ, 1);
    idle_cycles(3);

    // Starvation: both held high for 50 cycles
    rst_cycle();
    hold = 1; ifv_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick(); IF_REQ = 1; IF_ADDR = 32'h500; D_REQ = 1; D_WE = 0; D_ADDR = 32'h600;
      check_cycle();
      if (IF_VALID) ifv_cnt++;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("t6_ifv_cnt", ifv_cnt, 3);
`else
    chk("t6_ifv_cnt", ifv_cnt, 0);
`endif
    hold = 0;
    tick(); IF_REQ = 0; D_REQ = 0; check_cycle();
    idle_cycles(3);

    // Random traffic
    rst_cycle();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 299) == 0) RST = 1;
      if (!IF_REQ && $urandom_range(0, 2) == 0) begin
        IF_REQ = 1; IF_ADDR = $urandom & 32'hFFFF_FFFC;
      end else if (IF_REQ && $urandom_range(0, 49) == 0) IF_REQ = 0;
      if (!D_REQ && $urandom_range(0, 2) == 0) begin
        D_REQ = 1; D_WE = 1'($urandom_range(0, 1)); D_ADDR = $urandom;
        D_WDATA = $urandom; D_TYPE = 3'($urandom_range(0, 7));
      end else if (D_REQ && $urandom_range(0, 49) == 0) D_REQ = 0;
      check_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
